// File: rtl/adc_align_pkg.sv
// Shared types and default parameters for the ADC frame-clock alignment controller.
package adc_align_pkg;

    localparam int         DEF_NUM_LANES     = 4;
    localparam logic [7:0] DEF_FCO_PATTERN   = 8'hF0;
    localparam int         DEF_SETTLE_CYCLES = 8;
    localparam int         DEF_MAX_SLIPS     = 8;
    localparam int         DEF_LOSS_LIMIT    = 4;

    // One-hot controller states; any other encoding is treated as illegal.
    typedef enum logic [4:0] {
        ST_STARTUP = 5'b00001,
        ST_POLL    = 5'b00010,
        ST_SLIP    = 5'b00100,
        ST_LOCKED  = 5'b01000,
        ST_FAIL    = 5'b10000
    } align_state_e;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fco_lock_mon.sv
// Counts consecutive mismatching frame-clock words while locked and flags loss of lock.
module fco_lock_mon
    import adc_align_pkg::*;
#(
    parameter int LOSS_LIMIT = DEF_LOSS_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic match,
    input  logic enable,
    input  logic clear,
    output logic lost
);

    localparam int            CW       = cnt_w(LOSS_LIMIT);
    localparam logic [CW-1:0] MIS_LAST = CW'(LOSS_LIMIT - 1);

    logic [CW-1:0] mis_q, mis_d;

    // Loss is declared on the mismatch that would bring the run up to the limit.
    assign lost = enable && !match && (mis_q == MIS_LAST);

    // Run length of mismatches: any good word, a declared loss or a clear restarts it.
    always_comb begin
        mis_d = mis_q;
        if (clear || !enable || match || lost) begin
            mis_d = '0;
        end else begin
            mis_d = mis_q + 1'b1;
        end
    end

    // Mismatch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
        end
    end

endmodule

// File: rtl/adc_align_ctrl.sv
// Frame-clock driven bitslip alignment controller for a multi-lane ISERDES ADC receiver.
// The FCO word is compared against the expected pattern; on mismatch one bitslip strobe
// is sent to the FCO and all data lanes together, followed by a settle period.
module adc_align_ctrl
    import adc_align_pkg::*;
#(
    parameter int         NUM_LANES     = DEF_NUM_LANES,
    parameter logic [7:0] FCO_PATTERN   = DEF_FCO_PATTERN,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int         MAX_SLIPS     = DEF_MAX_SLIPS,
    parameter int         LOSS_LIMIT    = DEF_LOSS_LIMIT
) (
    input  logic                 CLKDIV,
    input  logic                 rst,
    input  logic [7:0]           ISERDES_FCO,
    input  logic                 realign,
    output logic                 ISERDES_bslip,
    output logic [NUM_LANES-1:0] data_bslip,
    output logic                 aligned,
    output logic                 align_fail,
    output logic                 lock_lost,
    output logic [3:0]           slip_count
);

    localparam int            SW          = cnt_w(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);

    align_state_e  state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    slip_q, slip_d;
    logic          slip_strobe;
    logic          fco_match;
    logic          mon_enable;
    logic          mon_clear;
    logic          mon_lost;

    assign fco_match  = (ISERDES_FCO == FCO_PATTERN);
    assign mon_enable = (state_q == ST_LOCKED);
    assign mon_clear  = realign || (state_q != ST_LOCKED);

    fco_lock_mon #(
        .LOSS_LIMIT (LOSS_LIMIT)
    ) u_lock_mon (
        .clk    (CLKDIV),
        .rst    (rst),
        .match  (fco_match),
        .enable (mon_enable),
        .clear  (mon_clear),
        .lost   (mon_lost)
    );

    // Next-state, counter and strobe decode for the alignment sequence.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        slip_d      = slip_q;
        slip_strobe = 1'b0;
        case (state_q)
            ST_STARTUP, ST_SLIP: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_POLL;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_POLL: begin
                settle_d = '0;
                if (fco_match) begin
                    state_d = ST_LOCKED;
                end else if (slip_q >= SLIP_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    slip_strobe = 1'b1;
                    slip_d      = slip_q + 4'd1;
                    state_d     = ST_SLIP;
                end
            end
            ST_LOCKED: begin
                // Realign takes priority over a simultaneous loss of lock.
                if (realign) begin
                    state_d  = ST_STARTUP;
                    slip_d   = '0;
                    settle_d = '0;
                end else if (mon_lost) begin
                    state_d = ST_POLL;
                    slip_d  = '0;
                end
            end
            ST_FAIL: begin
                if (realign) begin
                    state_d  = ST_STARTUP;
                    slip_d   = '0;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = ST_STARTUP;
                slip_d   = '0;
                settle_d = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            state_q  <= ST_STARTUP;
            settle_q <= '0;
            slip_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            slip_q   <= slip_d;
        end
    end

    // Pulse outputs are held quiet while reset is asserted.
    assign ISERDES_bslip = slip_strobe & ~rst;
    assign data_bslip    = {NUM_LANES{ISERDES_bslip}};
    assign lock_lost     = mon_lost & ~rst;
    assign aligned       = (state_q == ST_LOCKED);
    assign align_fail    = (state_q == ST_FAIL);
    assign slip_count    = slip_q;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Bench for adc_align_ctrl: an FCO ISERDES whose word phase advances on each bitslip,
// random bad words, and directed lock/loss/realign/reset sequences.
module tb_adc_align_ctrl;

    localparam int NL = 4;

    logic          CLKDIV = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    ISERDES_FCO = 8'h00;
    logic          realign = 1'b0;
    logic          ISERDES_bslip;
    logic [NL-1:0] data_bslip;
    logic          aligned;
    logic          align_fail;
    logic          lock_lost;
    logic [3:0]    slip_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   phase = 0;
    int   mode = 0;
    int   p_rand;
    logic prev_sl = 1'b0;
    int   strobes[$];

    adc_align_ctrl dut (
        .CLKDIV        (CLKDIV),
        .rst           (rst),
        .ISERDES_FCO   (ISERDES_FCO),
        .realign       (realign),
        .ISERDES_bslip (ISERDES_bslip),
        .data_bslip    (data_bslip),
        .aligned       (aligned),
        .align_fail    (align_fail),
        .lock_lost     (lock_lost),
        .slip_count    (slip_count)
    );

    always #5 CLKDIV = ~CLKDIV;

    // Word seen by the FCO deserializer at a given bit phase (phase 0 = aligned).
    function automatic logic [7:0] fco_word(input int p);
        logic [15:0] d;
        d = {8'hF0, 8'hF0} << p;
        return d[15:8];
    endfunction

    function automatic logic [7:0] bad_word();
        logic [7:0] w;
        w = 8'($urandom);
        if (w == 8'hF0) w = 8'h0F;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fco(input logic [7:0] w);
        ISERDES_FCO = w;
        #1;
    endtask

    // One clock: record strobes, check lane equality and strobe spacing, advance FCO model.
    task automatic step();
        logic sl;
        sl = ISERDES_bslip;
        if (sl === 1'b1) strobes.push_back(cyc);
        check("lanes_equal", 32'(data_bslip), 32'({NL{ISERDES_bslip}}));
        check("no_double_strobe", 32'(sl & prev_sl), 32'd0);
        prev_sl = sl;
        @(posedge CLKDIV);
        #1;
        cyc++;
        if (mode == 0) begin
            if (sl === 1'b1) phase = (phase + 1) % 8;
            ISERDES_FCO = fco_word(phase);
        end else if (mode == 1) begin
            ISERDES_FCO = bad_word();
        end
        #1;
    endtask

    task automatic do_reset(input int p0, input int m);
        rst = 1'b1;
        realign = 1'b0;
        mode = m;
        phase = p0;
        ISERDES_FCO = (m == 1) ? bad_word() : fco_word(p0);
        step();
        step();
        check("rst_aligned", 32'(aligned), 32'd0);
        check("rst_align_fail", 32'(align_fail), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);
        check("rst_bslip", 32'(ISERDES_bslip), 32'd0);
        check("rst_slip_count", 32'(slip_count), 32'd0);
        rst = 1'b0;
        #1;
        cyc = 0;
        prev_sl = 1'b0;
        strobes.delete();
    endtask

    task automatic run_to_settle(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (aligned === 1'b1 || align_fail === 1'b1) break;
            step();
        end
    endtask

    // From a fresh STARTUP with the FCO at phase p0: expected slips, strobe cycles, lock cycle.
    task automatic check_align(input string tag, input int p0);
        int k;
        k = (8 - p0) % 8;
        run_to_settle(300);
        check({tag, "_aligned"}, 32'(aligned), 32'd1);
        check({tag, "_lock_cycle"}, cyc, 8 + 9 * k + 1);
        check({tag, "_nstrobes"}, strobes.size(), k);
        for (int i = 0; i < strobes.size() && i < k; i++)
            check({tag, "_strobe_cyc"}, strobes[i], 8 + 9 * i);
        check({tag, "_slip_count"}, 32'(slip_count), k);
    endtask

    initial begin
        // Aligned from the start: POLL at cycle 8, lock at cycle 9, no strobes.
        do_reset(0, 0);
        check_align("fco_ok", 0);

        // Three slips needed.
        do_reset(5, 0);
        check_align("three_slips", 5);

        // Random starting phases.
        for (int t = 0; t < 4; t++) begin
            p_rand = int'($urandom_range(7));
            do_reset(p_rand, 0);
            check_align("rand_phase", p_rand);
        end

        // Loss-of-lock monitor: runs of 3 bad words separated by good ones keep lock.
        mode = 2;
        for (int i = 0; i < 11; i++) begin
            set_fco(((i % 4) == 3) ? 8'hF0 : bad_word());
            check("mon_no_loss", 32'(lock_lost), 32'd0);
            check("mon_still_aligned", 32'(aligned), 32'd1);
            step();
        end
        set_fco(bad_word());
        check("mon_loss_pulse", 32'(lock_lost), 32'd1);
        step();
        set_fco(bad_word());
        check("mon_loss_one_cycle", 32'(lock_lost), 32'd0);
        check("mon_loss_unaligned", 32'(aligned), 32'd0);
        check("mon_loss_slip_clear", 32'(slip_count), 32'd0);
        check("mon_loss_poll_strobe", 32'(ISERDES_bslip), 32'd1);
        step();
        check("mon_loss_slip_one", 32'(slip_count), 32'd1);

        // FCO never matches: 8 strobes then FAIL, held until realign.
        do_reset(0, 1);
        run_to_settle(300);
        check("fail_flag", 32'(align_fail), 32'd1);
        check("fail_aligned", 32'(aligned), 32'd0);
        check("fail_cycle", cyc, 81);
        check("fail_nstrobes", strobes.size(), 8);
        for (int i = 0; i < strobes.size() && i < 8; i++)
            check("fail_strobe_cyc", strobes[i], 8 + 9 * i);
        check("fail_slip_count", 32'(slip_count), 32'd8);
        repeat (20) step();
        check("fail_held", 32'(align_fail), 32'd1);
        check("fail_no_more_strobes", strobes.size(), 8);
        check("fail_slip_saturated", 32'(slip_count), 32'd8);
        realign = 1'b1;
        step();
        realign = 1'b0;
        check("realign_fail_clear", 32'(align_fail), 32'd0);
        check("realign_slip_clear", 32'(slip_count), 32'd0);
        mode = 0;
        phase = 0;
        set_fco(8'hF0);
        cyc = 0;
        strobes.delete();
        run_to_settle(300);
        check("realign_relock_cycle", cyc, 9);
        check("realign_relocked", 32'(aligned), 32'd1);

        // Realign coinciding with loss of lock: pulse still seen, restart via STARTUP.
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            set_fco(bad_word());
            step();
        end
        set_fco(bad_word());
        realign = 1'b1;
        #1;
        check("both_loss_pulse", 32'(lock_lost), 32'd1);
        step();
        realign = 1'b0;
        cyc = 0;
        check("both_lost_low", 32'(lock_lost), 32'd0);
        check("both_unaligned", 32'(aligned), 32'd0);
        mode = 0;
        phase = 0;
        set_fco(8'hF0);
        run_to_settle(300);
        check("both_startup_relock", cyc, 9);
        check("both_slip_count", 32'(slip_count), 32'd0);

        // Realign ignored in STARTUP and SLIP; reset mid-SLIP clears everything.
        do_reset(5, 0);
        while (cyc < 3) step();
        realign = 1'b1;
        step();
        realign = 1'b0;
        while (cyc < 12) step();
        realign = 1'b1;
        step();
        realign = 1'b0;
        while (cyc < 20) step();
        check("midslip_count", 32'(slip_count), 32'd2);
        check("midslip_nstrobes", strobes.size(), 2);
        if (strobes.size() == 2) begin
            check("midslip_strobe0", strobes[0], 8);
            check("midslip_strobe1", strobes[1], 17);
        end
        rst = 1'b1;
        step();
        check("midslip_rst_aligned", 32'(aligned), 32'd0);
        check("midslip_rst_fail", 32'(align_fail), 32'd0);
        check("midslip_rst_lost", 32'(lock_lost), 32'd0);
        check("midslip_rst_bslip", 32'(ISERDES_bslip), 32'd0);
        check("midslip_rst_data_bslip", 32'(data_bslip), 32'd0);
        check("midslip_rst_slip_count", 32'(slip_count), 32'd0);
        rst = 1'b0;
        #1;
        cyc = 0;
        prev_sl = 1'b0;
        strobes.delete();
        check_align("after_rst", phase);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_align_ctrl.md
ADC_ALIGN_CTRL -- requirements
Module: adc_align_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 4: number of ADC data lanes slaved to the frame-clock lane.
REQ-002 Parameter FCO_PATTERN, default 8'hF0: deserialized frame-clock word indicating alignment.
REQ-003 Parameter SETTLE_CYCLES, default 8: CLKDIV cycles waited after reset/realign and after each slip.
REQ-004 Parameter MAX_SLIPS, default 8: slip attempts before declaring failure.
REQ-005 Parameter LOSS_LIMIT, default 4: consecutive mismatching FCO words that drop lock.
REQ-006 CLKDIV  in  1  sole clock, ISERDES divided clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous to CLKDIV, active-high.
REQ-008 ISERDES_FCO  in  8  parallel frame-clock word from FCO ISERDES.
REQ-009 realign  in  1  single-cycle request to restart alignment.
REQ-010 ISERDES_bslip  out  1  bitslip strobe to FCO ISERDES.
REQ-011 data_bslip  out  NUM_LANES  bitslip strobes to data-lane ISERDES, one bit per lane.
REQ-012 aligned  out  1  high while locked.
REQ-013 align_fail  out  1  high while in failure state.
REQ-014 lock_lost  out  1  one-cycle pulse on loss of lock.
REQ-015 slip_count  out  4  slips issued in current attempt.

Function
REQ-016 States SHALL be STARTUP, POLL, SLIP, LOCKED, FAIL, one-hot; illegal encodings SHALL go to STARTUP next cycle.
REQ-017 STARTUP SHALL last exactly SETTLE_CYCLES cycles (settle counter 0..SETTLE_CYCLES-1), then go to POLL.
REQ-018 POLL, ISERDES_FCO == FCO_PATTERN: next state LOCKED, no strobe.
REQ-019 POLL, mismatch and slip_count == MAX_SLIPS: next state FAIL, no strobe.
REQ-020 POLL, mismatch and slip_count < MAX_SLIPS: ISERDES_bslip and all data_bslip bits high in that same cycle only, slip_count increments, next state SLIP.
REQ-021 SLIP SHALL last exactly SETTLE_CYCLES cycles, then go to POLL; strobes low throughout.
REQ-022 ISERDES_bslip and every data_bslip bit SHALL always be identical and never high two consecutive cycles.
REQ-023 aligned SHALL be high exactly when state is LOCKED; align_fail exactly when state is FAIL.
REQ-024 LOCKED: mismatch counter increments on each mismatching word, clears on any matching word; on reaching LOSS_LIMIT, lock_lost pulses one cycle, slip_count and mismatch counter clear, next state POLL.
REQ-025 realign in LOCKED or FAIL SHALL go to STARTUP, clearing slip_count, settle and mismatch counters; realign in STARTUP, POLL, SLIP SHALL be ignored.
REQ-026 realign and loss-of-lock in the same cycle: realign wins, lock_lost still pulses.
REQ-027 FAIL SHALL be held indefinitely until realign or rst.
REQ-028 slip_count SHALL saturate at MAX_SLIPS, never wrap.

Reset
REQ-029 rst high SHALL force, next edge, state STARTUP, all counters 0, all outputs 0, overriding any state including mid-SLIP.
REQ-030 Outputs SHALL remain 0 during rst; first POLL occurs SETTLE_CYCLES cycles after rst deasserts.

Structure
REQ-031 State enum and parameter defaults SHALL live in shared package adc_align_pkg.
REQ-032 Loss-of-lock counter SHALL be sub-module fco_lock_mon (inputs match, enable, clear; output lost).
REQ-033 Next-state/output logic SHALL be one combinational block; state and counters registered in one clocked block.

Verification
REQ-034 FCO held at 8'hF0 from reset -> first POLL at cycle 8, aligned high cycle 9, zero strobes, slip_count 0.
REQ-035 FCO model needing 3 slips -> exactly 3 single-cycle strobes, 9 cycles apart, all lanes equal; aligned high, slip_count 3.
REQ-036 FCO never 8'hF0 -> 8 strobes, then align_fail high, aligned low; realign pulse -> STARTUP, align_fail low, slip_count 0.
REQ-037 Locked; 3 bad words, 1 good, 3 bad -> no loss; then 4 consecutive bad -> lock_lost one-cycle pulse, aligned low, POLL next cycle.
REQ-038 rst asserted mid-SLIP (slip_count 2) -> all outputs 0 next edge; realign during SLIP -> no effect.
